// File: rtl/rstreq_sequencer.sv
// rtl/rstreq_sequencer.sv - reset-request pulse sequencer with synchronized ack handshake
// Collects reset requests, drives a minimum-width rst_req_o pulse, then waits for ack_ni release.
module rstreq_sequencer #(
  parameter int NumSrc        = 4,
  parameter int PulseCycles   = 16,
  parameter int TimeoutCycles = 1024,
  parameter int SyncStages    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] req_i,
  input  logic              ack_ni,
  output logic              rst_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [NumSrc-1:0] cause_o
);

  localparam int PcW = $clog2(PulseCycles) + 1;
  localparam int TcW = $clog2(TimeoutCycles) + 1;
  localparam logic [PcW-1:0] PcMax = PcW'(PulseCycles - 1);
  localparam logic [TcW-1:0] TcMax = TcW'(TimeoutCycles - 1);

  if (NumSrc < 1) begin : g_bad_num_src
    $fatal(1, "rstreq_sequencer: NumSrc must be >= 1");
  end
  if (PulseCycles < 2) begin : g_bad_pulse_cycles
    $fatal(1, "rstreq_sequencer: PulseCycles must be >= 2");
  end
  if (TimeoutCycles < 4) begin : g_bad_timeout_cycles
    $fatal(1, "rstreq_sequencer: TimeoutCycles must be >= 4");
  end
  if (SyncStages < 2) begin : g_bad_sync_stages
    $fatal(1, "rstreq_sequencer: SyncStages must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [PcW-1:0]        pc_q, pc_d;
  logic [TcW-1:0]        tc_q, tc_d;
  logic [NumSrc-1:0]     pend_q, pend_d;
  logic [NumSrc-1:0]     cause_d;
  logic                  timeout_d;
  logic [SyncStages-1:0] ack_sync_q;
  logic                  ack_s;

  // ack_ni is asynchronous to clk_i; only the last stage is used by the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SyncStages-2:0], ack_ni};
    end
  end

  assign ack_s = ack_sync_q[SyncStages-1];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tc_d      = tc_q;
    pend_d    = pend_q;
    cause_d   = cause_o;
    timeout_d = timeout_o;

    case (state_q)
      ST_IDLE: begin
        if ((|req_i) || (|pend_q)) begin
          cause_d = req_i | pend_q;
          pend_d  = '0;
          pc_d    = '0;
          tc_d    = '0;
          state_d = ST_ASSERT;
        end
      end

      ST_ASSERT: begin
        cause_d = cause_o | req_i;
        // The timeout window opens only once the minimum pulse width is met.
        if (pc_q != PcMax) begin
          pc_d = pc_q + PcW'(1);
        end else if (!ack_s) begin
          tc_d    = '0;
          state_d = ST_RELEASE;
        end else if (tc_q == TcMax) begin
          timeout_d = 1'b1;
          tc_d      = '0;
          state_d   = ST_RELEASE;
        end else begin
          tc_d = tc_q + TcW'(1);
        end
      end

      ST_RELEASE: begin
        pend_d = pend_q | req_i;
        if (ack_s) begin
          state_d = ST_DONE;
        end else if (tc_q == TcMax) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tc_d = tc_q + TcW'(1);
        end
      end

      ST_DONE: begin
        pend_d  = pend_q | req_i;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are loaded from the next state so they are glitch-free flop outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ASSERT;
      pc_q      <= '0;
      tc_q      <= '0;
      pend_q    <= '0;
      cause_o   <= '0;
      timeout_o <= 1'b0;
      rst_req_o <= 1'b1;
      busy_o    <= 1'b1;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tc_q      <= tc_d;
      pend_q    <= pend_d;
      cause_o   <= cause_d;
      timeout_o <= timeout_d;
      rst_req_o <= (state_d == ST_ASSERT);
      busy_o    <= (state_d != ST_IDLE);
      done_o    <= (state_d == ST_DONE);
    end
  end

endmodule
